// File: rtl/sol32_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sol32_mem_arbiter - round-robin fetch/data arbiter for one memory bus
// Rev 1.0
// ----------------------------------------------------------------------------
module sol32_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        FetchRequest,
    input  logic [31:0] FetchAddress,
    output logic [31:0] FetchData,
    output logic        FetchDone,
    input  logic        ReadEnable,
    input  logic        WriteEnable,
    input  logic [1:0]  DataWidth,
    input  logic [31:0] MemoryAddress,
    input  logic [31:0] DataOut,
    output logic [31:0] DataIn,
    output logic        DataDone,
    output logic        BusError,
    output logic        MemRequest,
    output logic        MemWrite,
    output logic [3:0]  MemByteEnable,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData,
    input  logic        MemAck
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        last_data;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_width;
    logic        lat_write;
    logic [7:0]  wait_cnt;

    logic        fetch_pend;
    logic        data_pend;
    logic        grant_data;
    logic        grant_fetch;
    logic        misaligned;
    logic        busy;
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [31:0] rd_shifted;
    logic [31:0] load_value;

    // A requester whose Done is high this cycle is still holding its
    // request from the finished transaction and must not be re-granted.
    always_comb begin
        fetch_pend  = FetchRequest & ~FetchDone;
        data_pend   = (ReadEnable | WriteEnable) & ~DataDone;
        grant_data  = data_pend & (~fetch_pend | ~last_data);
        grant_fetch = fetch_pend & ~grant_data;
        misaligned  = 1'b0;
        if (DataWidth == 2'b01) begin
            misaligned = MemoryAddress[0];
        end else if (DataWidth[1]) begin
            misaligned = (MemoryAddress[1:0] != 2'b00);
        end
    end

    always_comb begin
        lane_en   = 4'b1111;
        lane_data = lat_wdata;
        if (state == S_DATA) begin
            case (lat_width)
                2'b00: begin
                    lane_en   = 4'b0001 << lat_addr[1:0];
                    lane_data = {4{lat_wdata[7:0]}};
                end
                2'b01: begin
                    lane_en   = 4'b0011 << lat_addr[1:0];
                    lane_data = {2{lat_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_shifted = MemReadData >> {lat_addr[1:0], 3'b000};
        case (lat_width)
            2'b00:   load_value = {24'd0, rd_shifted[7:0]};
            2'b01:   load_value = {16'd0, rd_shifted[15:0]};
            default: load_value = MemReadData;
        endcase
        if (lat_write) begin
            load_value = 32'd0;
        end
    end

    assign busy          = (state != S_IDLE);
    assign MemRequest    = busy;
    assign MemWrite      = busy & lat_write;
    assign MemByteEnable = busy ? lane_en : 4'b0000;
    assign MemAddress    = busy ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign MemWriteData  = busy ? lane_data : 32'd0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            last_data <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_width <= 2'b00;
            lat_write <= 1'b0;
            wait_cnt  <= 8'd0;
            FetchData <= 32'd0;
            FetchDone <= 1'b0;
            DataIn    <= 32'd0;
            DataDone  <= 1'b0;
            BusError  <= 1'b0;
        end else begin
            FetchDone <= 1'b0;
            DataDone  <= 1'b0;
            BusError  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_data) begin
                        last_data <= 1'b1;
                        if (misaligned) begin
                            DataDone <= 1'b1;
                            BusError <= 1'b1;
                            DataIn   <= 32'd0;
                        end else begin
                            state     <= S_DATA;
                            lat_addr  <= MemoryAddress;
                            lat_width <= DataWidth;
                            lat_write <= WriteEnable;
                            lat_wdata <= DataOut;
                            wait_cnt  <= 8'd0;
                        end
                    end else if (grant_fetch) begin
                        last_data <= 1'b0;
                        state     <= S_FETCH;
                        lat_addr  <= FetchAddress;
                        lat_width <= 2'b10;
                        lat_write <= 1'b0;
                        lat_wdata <= 32'd0;
                        wait_cnt  <= 8'd0;
                    end
                end
                S_FETCH, S_DATA: begin
                    // An acknowledge in the last allowed cycle still wins over the abort.
                    if (MemAck) begin
                        state <= S_IDLE;
                        if (state == S_FETCH) begin
                            FetchDone <= 1'b1;
                            FetchData <= MemReadData;
                        end else begin
                            DataDone <= 1'b1;
                            DataIn   <= load_value;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= S_IDLE;
                        BusError <= 1'b1;
                        if (state == S_FETCH) begin
                            FetchDone <= 1'b1;
                            FetchData <= 32'd0;
                        end else begin
                            DataDone <= 1'b1;
                            DataIn   <= 32'd0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sol32_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sol32_mem_arbiter - vector table, corner sequences and random traffic
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sol32_mem_arbiter;

    localparam int TIMEOUT = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        FetchRequest;
    logic [31:0] FetchAddress;
    logic [31:0] FetchData;
    logic        FetchDone;
    logic        ReadEnable;
    logic        WriteEnable;
    logic [1:0]  DataWidth;
    logic [31:0] MemoryAddress;
    logic [31:0] DataOut;
    logic [31:0] DataIn;
    logic        DataDone;
    logic        BusError;
    logic        MemRequest;
    logic        MemWrite;
    logic [3:0]  MemByteEnable;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic [31:0] MemReadData;
    logic        MemAck;

    sol32_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset),
        .FetchRequest(FetchRequest), .FetchAddress(FetchAddress),
        .FetchData(FetchData), .FetchDone(FetchDone),
        .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .DataWidth(DataWidth), .MemoryAddress(MemoryAddress),
        .DataOut(DataOut), .DataIn(DataIn), .DataDone(DataDone),
        .BusError(BusError), .MemRequest(MemRequest), .MemWrite(MemWrite),
        .MemByteEnable(MemByteEnable), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData), .MemAck(MemAck)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        bit        fetch;
        bit        write;
        bit [1:0]  width;
        bit [31:0] addr;
        bit [31:0] wdata;
    } req_t;

    int        m_owner;       // 0 bus free, 1 fetch owns it, 2 data owns it
    req_t      m_req;
    int        m_waited;
    bit        m_last_data;
    bit        m_fdone, m_ddone, m_err;
    bit [31:0] m_fdata, m_din;
    bit        m_valid = 1'b0;
    bit        m_rst;

    function automatic int acc_size(input req_t r);
        if (r.fetch) return 4;
        case (r.width)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_off(input req_t r);
        return (acc_size(r) == 4) ? 0 : int'(r.addr[1:0]);
    endfunction

    function automatic bit [3:0] lanes(input req_t r);
        bit [3:0] m = 4'b0000;
        for (int l = 0; l < 4; l++)
            m[l] = (l >= lane_off(r)) && (l < lane_off(r) + acc_size(r));
        return m;
    endfunction

    function automatic bit [31:0] lane_bits(input bit [3:0] m);
        bit [31:0] b = 32'd0;
        for (int l = 0; l < 4; l++) b[l*8 +: 8] = {8{m[l]}};
        return b;
    endfunction

    function automatic bit [31:0] placed(input req_t r);
        bit [31:0] d = 32'd0;
        for (int l = 0; l < 4; l++)
            if (lanes(r)[l]) d[l*8 +: 8] = r.wdata[(l - lane_off(r))*8 +: 8];
        return d;
    endfunction

    function automatic bit [31:0] load_of(input req_t r, input bit [31:0] rd);
        bit [31:0] v = 32'd0;
        if (r.write) return 32'd0;
        for (int k = 0; k < acc_size(r); k++) v[k*8 +: 8] = rd[(lane_off(r) + k)*8 +: 8];
        return v;
    endfunction

    function automatic bit is_misaligned(input req_t r);
        return (acc_size(r) == 2 && r.addr[0]) || (acc_size(r) == 4 && r.addr[1:0] != 2'b00);
    endfunction

    // Called at each rising edge with the inputs of the cycle that is ending.
    task automatic model_step();
        bit fp, dp, nf, nd, ne;
        bit [31:0] nfd, ndin;
        req_t r;
        nf = 0; nd = 0; ne = 0; nfd = 0; ndin = 0;
        if (Reset) begin
            m_owner = 0; m_last_data = 0; m_fdone = 0; m_ddone = 0; m_err = 0;
            m_valid = 1; m_rst = 1;
            return;
        end
        m_rst = 0;
        if (m_owner == 0) begin
            fp = FetchRequest && !m_fdone;
            dp = (ReadEnable || WriteEnable) && !m_ddone;
            if (dp && (!fp || !m_last_data)) begin
                r.fetch = 0; r.write = WriteEnable; r.width = DataWidth;
                r.addr = MemoryAddress; r.wdata = DataOut;
                m_last_data = 1;
                if (is_misaligned(r)) begin
                    nd = 1; ne = 1;
                end else begin
                    m_owner = 2; m_req = r; m_waited = 0;
                end
            end else if (fp) begin
                r.fetch = 1; r.write = 0; r.width = 2'd2; r.addr = FetchAddress; r.wdata = 0;
                m_owner = 1; m_req = r; m_waited = 0; m_last_data = 0;
            end
        end else begin
            m_waited++;
            if (MemAck || m_waited == TIMEOUT) begin
                ne = !MemAck;
                if (m_owner == 1) begin
                    nf = 1; nfd = MemAck ? MemReadData : 32'd0;
                end else begin
                    nd = 1; ndin = MemAck ? load_of(m_req, MemReadData) : 32'd0;
                end
                m_owner = 0;
            end
        end
        m_fdone = nf; m_ddone = nd; m_err = ne; m_fdata = nfd; m_din = ndin;
    endtask

    task automatic check_model();
        if (!m_valid) return;
        if (m_rst) begin
            chk("rst_ctrl", {FetchDone, DataDone, BusError, MemRequest, MemWrite, MemByteEnable}, 0);
            chk("rst_fetch_data", FetchData, 0);
            chk("rst_data_in", DataIn, 0);
            chk("rst_mem_addr", MemAddress, 0);
            chk("rst_mem_wdata", MemWriteData, 0);
            return;
        end
        chk("mem_request", MemRequest, m_owner != 0);
        chk("done_flags", {FetchDone, DataDone, BusError}, {m_fdone, m_ddone, m_err});
        if (m_owner != 0) begin
            chk("mem_addr", MemAddress, {m_req.addr[31:2], 2'b00});
            chk("mem_be", MemByteEnable, lanes(m_req));
            chk("mem_write", MemWrite, m_req.write);
            if (m_req.write)
                chk("mem_wdata", MemWriteData & lane_bits(lanes(m_req)), placed(m_req));
        end
        if (m_fdone) chk("fetch_data", FetchData, m_fdata);
        if (m_ddone) chk("data_in", DataIn, m_din);
    endtask

    task automatic half1();
        @(negedge Clock);
        check_model();
    endtask

    task automatic half2();
        @(posedge Clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        FetchRequest = 0; FetchAddress = 0; ReadEnable = 0; WriteEnable = 0;
        DataWidth = 0; MemoryAddress = 0; DataOut = 0; MemAck = 0; MemReadData = 0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        Reset = 1;
        half1(); half2();
        Reset = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit fetch; bit write; bit [1:0] width;
        bit [31:0] addr; bit [31:0] wdata; bit [31:0] rdata; int delay;
        bit exp_req; bit [3:0] exp_be; bit [31:0] exp_maddr; bit [31:0] exp_wdata;
        bit [31:0] exp_rdata; bit exp_err; int exp_lat;
    } vec_t;

    function automatic vec_t mkv(bit f, bit w, bit [1:0] wd, bit [31:0] a, bit [31:0] wdat,
                                 bit [31:0] rd, int dly, bit er, bit [3:0] be, bit [31:0] ma,
                                 bit [31:0] ew, bit [31:0] erd, bit eerr, int lat);
        vec_t v;
        v.fetch = f; v.write = w; v.width = wd; v.addr = a; v.wdata = wdat; v.rdata = rd;
        v.delay = dly; v.exp_req = er; v.exp_be = be; v.exp_maddr = ma; v.exp_wdata = ew;
        v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = lat;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        bit done;
        FetchRequest = v.fetch; FetchAddress = v.fetch ? v.addr : 32'd0;
        ReadEnable = !v.fetch && !v.write; WriteEnable = !v.fetch && v.write;
        DataWidth = v.width; MemoryAddress = v.addr; DataOut = v.wdata;
        MemAck = 0; MemReadData = v.rdata;
        half1(); half2();
        done = 0;
        for (int cyc = 1; cyc <= TIMEOUT + 3 && !done; cyc++) begin
            MemAck = MemRequest && (cyc == v.delay + 1);
            half1();
            if (cyc == 1) begin
                chk($sformatf("vec%0d_req", idx), MemRequest, v.exp_req);
                if (MemRequest) begin
                    chk($sformatf("vec%0d_be", idx), MemByteEnable, v.exp_be);
                    chk($sformatf("vec%0d_maddr", idx), MemAddress, v.exp_maddr);
                    if (v.write)
                        chk($sformatf("vec%0d_wdata", idx), MemWriteData & lane_bits(v.exp_be), v.exp_wdata);
                end
            end
            if (FetchDone || DataDone) begin
                done = 1;
                chk($sformatf("vec%0d_latency", idx), cyc, v.exp_lat);
                chk($sformatf("vec%0d_kind", idx), FetchDone, v.fetch);
                chk($sformatf("vec%0d_err", idx), BusError, v.exp_err);
                chk($sformatf("vec%0d_rdata", idx), v.fetch ? FetchData : DataIn, v.exp_rdata);
            end
            half2();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL vec%0d_done: got no Done expected one within %0d cycles", idx, TIMEOUT + 3);
        end
        idle_inputs();
        half1(); half2(); half1(); half2();
    endtask

    vec_t vecs[14];

    initial begin
        bit f_hold, d_hold, f_got, d_got, prev_req;
        int ack_dly, mcnt, ndone, nreq, t_done;
        int d_cyc[4];
        bit d_kind[4];

        vecs[0]  = mkv(1,0,2,'h100,0,'h12345678,0,     1,'hF,'h100,0,'h12345678,0,2);
        vecs[1]  = mkv(0,0,0,'h203,0,'hAB000000,0,     1,'h8,'h200,0,'hAB,0,2);
        vecs[2]  = mkv(0,1,1,'h202,'hBEEF,0,0,         1,'hC,'h200,'hBEEF0000,0,0,2);
        vecs[3]  = mkv(0,0,2,'h201,0,'hFFFFFFFF,0,     0,0,0,0,0,1,1);
        vecs[4]  = mkv(0,0,1,'h102,0,'hCAFE1234,2,     1,'hC,'h100,0,'hCAFE,0,4);
        vecs[5]  = mkv(0,1,0,'h001,'h5A,0,0,           1,'h2,'h0,'h5A00,0,0,2);
        vecs[6]  = mkv(0,1,3,'h040,'hDEADBEEF,0,1,     1,'hF,'h40,'hDEADBEEF,0,0,3);
        vecs[7]  = mkv(0,0,1,'h105,0,'h1,0,            0,0,0,0,0,1,1);
        vecs[8]  = mkv(0,0,2,'h300,0,'h55555555,255,   1,'hF,'h300,0,0,1,5);
        vecs[9]  = mkv(1,0,2,'h204,0,'h77777777,255,   1,'hF,'h204,0,0,1,5);
        vecs[10] = mkv(0,0,0,'h002,0,'h11FF2233,0,     1,'h4,'h0,0,'hFF,0,2);
        vecs[11] = mkv(0,0,2,'h010,0,'h89ABCDEF,3,     1,'hF,'h10,0,'h89ABCDEF,0,5);
        vecs[12] = mkv(0,0,1,'h000,0,'h1234ABCD,0,     1,'h3,'h0,0,'hABCD,0,2);
        vecs[13] = mkv(0,1,1,'h003,'h1234,0,0,         0,0,0,0,0,1,1);

        idle_inputs();
        Reset = 1;
        half2();
        half1();
        chk("reset_mem_request", MemRequest, 0);
        half2();
        Reset = 0;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Both requesters held, zero-wait memory: grants alternate starting with data.
        reset_pulse();
        FetchRequest = 1; FetchAddress = 32'h400;
        ReadEnable = 1; DataWidth = 2'd2; MemoryAddress = 32'h500;
        ndone = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            MemAck = MemRequest;
            MemReadData = $urandom;
            half1();
            if ((FetchDone || DataDone) && ndone < 4) begin
                d_cyc[ndone] = cyc; d_kind[ndone] = DataDone; ndone++;
            end
            half2();
        end
        chk("alt_count", ndone, 4);
        for (int k = 0; k < 4 && k < ndone; k++) begin
            chk($sformatf("alt_kind%0d", k), d_kind[k], (k % 2) == 0);
            chk($sformatf("alt_cycle%0d", k), d_cyc[k], 2 + 2*k);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin half1(); half2(); end

        // Data load times out while a fetch waits; the fetch is granted on the Done cycle.
        reset_pulse();
        ReadEnable = 1; DataWidth = 2'd2; MemoryAddress = 32'h300;
        FetchRequest = 1; FetchAddress = 32'h600;
        nreq = 0; t_done = -1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            half1();
            if (t_done < 0 && MemRequest) nreq++;
            if (t_done < 0 && DataDone) begin
                t_done = cyc;
                chk("to_err", BusError, 1);
                chk("to_data_in", DataIn, 0);
            end
            if (t_done >= 0 && cyc == t_done + 1)
                chk("to_fetch_grant", {MemRequest, MemAddress}, {1'b1, 32'h600});
            half2();
            if (t_done >= 0) ReadEnable = 0;
        end
        chk("to_req_cycles", nreq, TIMEOUT);
        chk("to_done_cycle", t_done, TIMEOUT + 1);
        idle_inputs();
        for (int k = 0; k < 8; k++) begin half1(); half2(); end

        // Reset in the second wait cycle of a fetch, request kept high.
        reset_pulse();
        FetchRequest = 1; FetchAddress = 32'h700; MemReadData = 32'hA5A5_0F0F;
        for (int cyc = 0; cyc < 7; cyc++) begin
            Reset = (cyc == 2);
            MemAck = (cyc == 4) && MemRequest;
            half1();
            if (cyc == 3) chk("rst_mid_idle", {MemRequest, FetchDone}, 2'b00);
            if (cyc == 4) chk("rst_mid_regrant", {MemRequest, MemAddress}, {1'b1, 32'h700});
            if (cyc == 5) chk("rst_mid_done", {FetchDone, BusError, FetchData}, {2'b10, 32'hA5A5_0F0F});
            half2();
            if (cyc == 5) FetchRequest = 0;
        end
        Reset = 0;
        idle_inputs();
        half1(); half2();

        // Random traffic against the model.
        f_hold = 0; d_hold = 0; f_got = 0; d_got = 0; prev_req = 0; ack_dly = 0; mcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 299) == 0);
            if (f_hold && (f_got || $urandom_range(0, 39) == 0)) f_hold = 0;
            if (!f_hold && $urandom_range(0, 2) == 0) begin
                f_hold = 1; FetchAddress = $urandom;
            end
            FetchRequest = f_hold;
            if (d_hold && (d_got || $urandom_range(0, 39) == 0)) d_hold = 0;
            if (!d_hold && $urandom_range(0, 2) == 0) begin
                d_hold = 1;
                case ($urandom_range(0, 2))
                    0: begin ReadEnable = 1; WriteEnable = 0; end
                    1: begin ReadEnable = 0; WriteEnable = 1; end
                    default: begin ReadEnable = 1; WriteEnable = 1; end
                endcase
                DataWidth = 2'($urandom_range(0, 3));
                MemoryAddress = $urandom;
                DataOut = $urandom;
            end
            if (!d_hold) begin ReadEnable = 0; WriteEnable = 0; end
            if (MemRequest) begin
                if (!prev_req) begin mcnt = 0; ack_dly = $urandom_range(0, 5); end
                else mcnt++;
                MemAck = (mcnt == ack_dly);
            end else begin
                MemAck = ($urandom_range(0, 3) == 0);
            end
            prev_req = MemRequest;
            MemReadData = $urandom;
            half1();
            f_got = FetchDone; d_got = DataDone;
            half2();
        end
        Reset = 0;
        idle_inputs();
        for (int k = 0; k < 8; k++) begin half1(); half2(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
